result_vector_transmitter: RTL and testbench



---
 rtl/result_vector_transmitter.sv | 151 +++++++++++++++
 tb/tb_result_vector_transmitter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_vector_transmitter.sv
// Buffers NUM_CHANNELS-wide result bundles and serializes them little-endian,
// channel 0 first, into block transfers of up to BUNDLES_PER_BLOCK bundles.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | wait for a full block (or flushed remainder); report drained flush
// SEND      | present head bytes on tx_byte, advance on tx_byte_req
// WAIT_DONE | all bytes handed over, wait for the engine to drop tx_busy
module result_vector_transmitter #(
   parameter int         NUM_CHANNELS      = 4,
   parameter int         FIFO_DEPTH        = 8,
   parameter int         BUNDLES_PER_BLOCK = 4,
   parameter logic [2:0] ADDRESS           = 3'h3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CHANNELS-1:0][31:0] res_data,
   input  logic                          res_valid,
   output logic                          res_ready,
   input  logic                          flush,
   output logic                          tx_start,
   output logic [2:0]                    tx_addr,
   output logic [7:0]                    tx_length,
   output logic [7:0]                    tx_byte,
   input  logic                          tx_byte_req,
   input  logic                          tx_busy,
   output logic                          done,
   output logic                          overflow
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CHANNELS - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_BLOCK = CNT_W'(BUNDLES_PER_BLOCK);
   localparam logic [7:0]       BUNDLE_BYTES = 8'(4 * NUM_CHANNELS);
   localparam logic [7:0]       BLOCK_BYTES  = 8'(BUNDLES_PER_BLOCK * 4 * NUM_CHANNELS);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

   state_t                        state;
   logic [NUM_CHANNELS-1:0][31:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]              wr_ptr;
   logic [PTR_W-1:0]              rd_ptr;
   logic [CNT_W-1:0]              count;
   logic [1:0]                    byte_idx;
   logic [CH_W-1:0]               chan_idx;
   logic [7:0]                    sent;
   logic                          flush_pending;
   logic                          push;
   logic                          pop;
   logic                          launch;
   logic [7:0]                    launch_len;
   logic [31:0]                   head_word;

   assign tx_addr   = ADDRESS;
   assign res_ready = (count != CNT_FULL);
   assign push      = res_valid && res_ready;
   assign pop       = (state == SEND) && tx_byte_req && (byte_idx == 2'd3) && (chan_idx == CH_LAST);
   assign launch    = (count >= CNT_BLOCK) || (flush_pending && (count != '0));
   assign head_word = mem[rd_ptr][chan_idx];

   always_comb begin
      launch_len = BLOCK_BYTES;
      if (count < CNT_BLOCK)
         launch_len = 8'(count) * BUNDLE_BYTES;
   end

   // Gated so the byte lane reads zero outside SEND, including after reset.
   always_comb begin
      tx_byte = '0;
      if (state == SEND)
         tx_byte = head_word[{byte_idx, 3'b000} +: 8];
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= res_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (pop && !push)
            count <= count - CNT_W'(1);
         if (res_valid && !res_ready)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         tx_start      <= 1'b0;
         tx_length     <= '0;
         done          <= 1'b0;
         flush_pending <= 1'b0;
         byte_idx      <= '0;
         chan_idx      <= '0;
         sent          <= '0;
      end else begin
         tx_start <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (launch) begin
                  tx_start  <= 1'b1;
                  tx_length <= launch_len;
                  byte_idx  <= '0;
                  chan_idx  <= '0;
                  sent      <= '0;
                  state     <= SEND;
               end else if (flush_pending && (count == '0) && !tx_busy) begin
                  done          <= 1'b1;
                  flush_pending <= 1'b0;
               end
            end
            SEND: begin
               if (tx_byte_req) begin
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3)
                     chan_idx <= (chan_idx == CH_LAST) ? '0 : chan_idx + CH_W'(1);
                  sent <= sent + 8'd1;
                  if ((sent + 8'd1) == tx_length)
                     state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // A new flush always wins over the clear that accompanies done.
         if (flush)
            flush_pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_result_vector_transmitter.sv
// Randomized bench for result_vector_transmitter: a queue-based model of the
// buffered byte stream and transfer sequencing, with the bench acting as the engine.
module tb_result_vector_transmitter;

   localparam int NC    = 4;
   localparam int DEPTH = 8;
   localparam int BPB   = 4;
   localparam int BB    = 4 * NC;

   logic                clk = 1'b0;
   logic                rst;
   logic [NC-1:0][31:0] res_data;
   logic                res_valid;
   logic                res_ready;
   logic                flush;
   logic                tx_start;
   logic [2:0]          tx_addr;
   logic [7:0]          tx_length;
   logic [7:0]          tx_byte;
   logic                tx_byte_req;
   logic                tx_busy;
   logic                done;
   logic                overflow;

   always #5 clk = ~clk;

   result_vector_transmitter #(
      .NUM_CHANNELS(NC), .FIFO_DEPTH(DEPTH), .BUNDLES_PER_BLOCK(BPB), .ADDRESS(3'h3)
   ) dut (
      .clk(clk), .rst(rst), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .flush(flush), .tx_start(tx_start), .tx_addr(tx_addr), .tx_length(tx_length),
      .tx_byte(tx_byte), .tx_byte_req(tx_byte_req), .tx_busy(tx_busy), .done(done),
      .overflow(overflow)
   );

   int total = 0;
   int bad   = 0;

   // Model: 0 = waiting for a block, 1 = bytes being handed over, 2 = engine finishing.
   int         m_phase;
   int         m_count;
   int         m_len;
   int         m_sent;
   int         m_consumed;
   bit         m_fp;
   bit         m_ovf;
   logic [7:0] exp_q[$];

   bit serve_en;
   bit stray_en;
   int req_pct;
   int busy_tail;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_count = 0; m_len = 0; m_sent = 0; m_consumed = 0;
      m_fp = 0; m_ovf = 0; busy_tail = 0;
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_start"},  32'(tx_start), 32'd0);
      check({tag, "_tx_length"}, 32'(tx_length), 32'd0);
      check({tag, "_tx_byte"},   32'(tx_byte), 32'd0);
      check({tag, "_done"},      32'(done), 32'd0);
      check({tag, "_overflow"},  32'(overflow), 32'd0);
      check({tag, "_res_ready"}, 32'(res_ready), 32'd1);
      check({tag, "_tx_addr"},   32'(tx_addr), 32'h3);
   endtask

   function automatic logic [NC*32-1:0] rand_bundle();
      logic [NC*32-1:0] r;
      for (int i = 0; i < NC; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic eng_drive(output logic rq, output logic bz);
      rq = 1'b0;
      bz = 1'b0;
      if (m_phase == 1) begin
         bz = 1'b1;
         busy_tail = $urandom_range(0, 2);
         rq = serve_en && ($urandom_range(0, 99) < req_pct);
      end else begin
         if (stray_en) rq = ($urandom_range(0, 7) == 0);
         if (m_phase == 2 && busy_tail > 0) begin
            busy_tail--;
            bz = 1'b1;
         end
      end
   endtask

   // One clock: drive inputs, advance the model over the edge, compare after it.
   task automatic cyc(input logic v, input logic [NC*32-1:0] d, input logic fl,
                      input logic rq, input logic bz);
      bit push, pop, e_start, e_done;
      res_valid = v; res_data = d; flush = fl; tx_byte_req = rq; tx_busy = bz;
      push = v && (m_count != DEPTH);
      pop = 0; e_start = 0; e_done = 0;
      if (v && m_count == DEPTH) m_ovf = 1;
      case (m_phase)
         0: begin
            if (m_count >= BPB || (m_fp && m_count > 0)) begin
               e_start = 1;
               m_len = ((m_count < BPB) ? m_count : BPB) * BB;
               m_sent = 0;
               m_phase = 1;
            end else if (m_fp && m_count == 0 && !bz) begin
               e_done = 1;
            end
         end
         1: begin
            if (rq) begin
               check("tx_byte", 32'(tx_byte), 32'(exp_q[0]));
               void'(exp_q.pop_front());
               m_consumed++;
               if (m_consumed % BB == 0) pop = 1;
               m_sent++;
               if (m_sent == m_len) m_phase = 2;
            end
         end
         default: if (!bz) m_phase = 0;
      endcase
      if (fl) m_fp = 1;
      else if (e_done) m_fp = 0;
      if (push)
         for (int c = 0; c < NC; c++)
            for (int b = 0; b < 4; b++) exp_q.push_back(d[c*32 + b*8 +: 8]);
      m_count = m_count + int'(push) - int'(pop);
      @(posedge clk);
      #1;
      check("tx_start",  32'(tx_start), 32'(e_start));
      check("done",      32'(done), 32'(e_done));
      check("res_ready", 32'(res_ready), 32'(m_count != DEPTH));
      check("overflow",  32'(overflow), 32'(m_ovf));
      if (m_phase != 0) check("tx_length", 32'(tx_length), 32'(m_len));
      res_valid = 0; flush = 0; tx_byte_req = 0;
   endtask

   task automatic tick(input logic v, input logic [NC*32-1:0] d, input logic fl);
      logic rq, bz;
      eng_drive(rq, bz);
      cyc(v, d, fl, rq, bz);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (!(m_phase == 0 && m_count == 0 && !m_fp) && n < budget) begin
         tick(1'b0, '0, 1'b0);
         n++;
      end
      check("drain_in_budget", 32'(n < budget), 32'd1);
      repeat (4) tick(1'b0, '0, 1'b0);
   endtask

   initial begin
      logic [NC*32-1:0] pat;
      int left;
      int n;
      rst = 1'b1; res_valid = 0; res_data = '0; flush = 0; tx_byte_req = 0; tx_busy = 0;
      model_reset();
      serve_en = 1; stray_en = 0; req_pct = 100;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (2) tick(1'b0, '0, 1'b0);

      // Full block with a recognisable pattern, served every cycle.
      for (int c = 0; c < NC; c++) pat[c*32 +: 32] = 32'h0C0B0A00 + 32'(c);
      for (int i = 0; i < 4; i++) tick(1'b1, pat, 1'b0);
      drain(200);

      // Partial block on flush.
      req_pct = 60;
      for (int i = 0; i < 2; i++) tick(1'b1, rand_bundle(), 1'b0);
      tick(1'b0, '0, 1'b1);
      drain(300);
      repeat (10) tick(1'b0, '0, 1'b0);

      // Flush with nothing buffered.
      tick(1'b0, '0, 1'b1);
      tick(1'b0, '0, 1'b0);
      check("empty_flush_done", 32'(done), 32'd1);
      repeat (5) tick(1'b0, '0, 1'b0);

      // Fill to full, then push into the slot freed by each later bundle pop.
      serve_en = 0;
      for (int i = 0; i < DEPTH; i++) tick(1'b1, rand_bundle(), 1'b0);
      serve_en = 1; req_pct = 100;
      left = 3; n = 0;
      while (left > 0 && n < 500) begin
         logic rq, bz, v;
         eng_drive(rq, bz);
         v = (m_phase == 1) && rq && ((m_consumed + 1) % BB == 0) && (m_count == DEPTH - 1);
         if (v) left--;
         cyc(v, rand_bundle(), 1'b0, rq, bz);
         n++;
      end
      check("pushpop_no_overflow", 32'(overflow), 32'd0);
      tick(1'b0, '0, 1'b1);
      drain(600);

      // Overrun with no service, then recover all accepted bundles.
      serve_en = 0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         tick(1'b1, rand_bundle(), 1'b0);
         if (i == DEPTH - 1) check("full_ready", 32'(res_ready), 32'd0);
      end
      check("overrun_overflow", 32'(overflow), 32'd1);
      serve_en = 1;
      drain(400);

      // Random traffic.
      stray_en = 1; req_pct = 70;
      for (int i = 0; i < 1500; i++)
         tick(($urandom_range(0, 99) < 40), rand_bundle(), ($urandom_range(0, 99) == 0));
      tick(1'b0, '0, 1'b1);
      drain(2000);
      check("leftover_bytes", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of a transfer.
      stray_en = 0; req_pct = 100;
      for (int i = 0; i < 4; i++) tick(1'b1, rand_bundle(), 1'b0);
      n = 0;
      while (!(m_phase == 1 && m_sent == 10) && n < 100) begin
         tick(1'b0, '0, 1'b0);
         n++;
      end
      check("reached_byte10", 32'(m_sent), 32'd10);
      rst = 1'b1;
      tx_busy = 0;
      #1;
      check_reset_outputs("midrst");
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("midrst_hold");
      rst = 1'b0;
      model_reset();
      stray_en = 1;
      repeat (20) tick(1'b0, '0, 1'b0);
      stray_en = 0;
      for (int i = 0; i < 4; i++) tick(1'b1, rand_bundle(), 1'b0);
      drain(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
